// File: rtl/finalproject1_soc_hex_display_pio.sv
// Avalon-MM hex display PIO: digit data register with set/clear aliases, per-digit
// blank and blink masks, a programmable blink timer and registered active-low 7-segment outputs.
module finalproject1_soc_hex_display_pio #(
  parameter int unsigned NUM_DIGITS         = 4,
  parameter logic [31:0] BLINK_RESET_PERIOD = 32'd25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    blink_phase
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_BLANK    = 3'd1,
    ADDR_BLINK    = 3'd2,
    ADDR_PERIOD   = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5
  } reg_addr_e;

  logic [W-1:0]          data_q,   data_d;
  logic [NUM_DIGITS-1:0] blank_q,  blank_d;
  logic [NUM_DIGITS-1:0] blink_q,  blink_d;
  logic [31:0]           period_q, period_d;
  logic [31:0]           cnt_q,    cnt_d;
  logic                  ph_q,     ph_d;
  logic [SW-1:0]         segs_q,   segs_d;

  logic wr_en;
  logic period_wr;

  assign wr_en     = chipselect && !write_n;
  assign period_wr = wr_en && (address == ADDR_PERIOD);

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Register file writes; OUTSET/OUTCLEAR are write-only aliases that modify DATA.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    data_d   = data_q;
    blank_d  = blank_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d   = writedata[W-1:0];
        ADDR_BLANK:    blank_d  = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:    blink_d  = writedata[NUM_DIGITS-1:0];
        ADDR_PERIOD:   period_d = writedata;
        ADDR_OUTSET:   data_d   = data_q | writedata[W-1:0];
        ADDR_OUTCLEAR: data_d   = data_q & ~writedata[W-1:0];
        default:       ;
      endcase
    end
  end

  // A PERIOD write restarts the timer visible-first and wins over a coincident wrap.
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (period_wr || period_q == 32'd0) begin
      cnt_d = 32'd0;
      ph_d  = 1'b1;
    end else if (cnt_q == period_q - 32'd1) begin
      cnt_d = 32'd0;
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    segs_d = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (blank_q[i] || (blink_q[i] && !ph_q)) segs_d[7*i +: 7] = 7'h7F;
      else                                     segs_d[7*i +: 7] = hex_font(data_q[4*i +: 4]);
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata[W-1:0]          = data_q;
      ADDR_BLANK:  readdata[NUM_DIGITS-1:0] = blank_q;
      ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_q;
      ADDR_PERIOD: readdata                 = period_q;
      default:     readdata                 = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      period_q <= BLINK_RESET_PERIOD;
      cnt_q    <= 32'd0;
      ph_q     <= 1'b1;
      segs_q   <= '1;
    end else begin
      data_q   <= data_d;
      blank_q  <= blank_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      segs_q   <= segs_d;
    end
  end

  assign out_port    = data_q;
  assign hex_segs    = segs_q;
  assign blink_phase = ph_q;

endmodule

// File: tb/tb_finalproject1_soc_hex_display_pio.sv
// Directed self-checking bench for the hex display PIO (NUM_DIGITS = 4, default blink period).
module tb_finalproject1_soc_hex_display_pio;

  localparam logic [27:0] SEGS_OFF  = 28'hFFFFFFF;
  localparam logic [27:0] SEGS_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic [27:0] hex_segs;
  logic        blink_phase;

  int errors = 0;
  int checks = 0;

  finalproject1_soc_hex_display_pio #(
    .NUM_DIGITS(4),
    .BLINK_RESET_PERIOD(32'd25000000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .hex_segs    (hex_segs),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [2:0] a, input logic [31:0] d, input logic cs, input logic wn);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = wn;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    logic [27:0] exp_segs;
    logic        exp_ph;

    // Reset values
    #12;
    check("rst_segs", 32'(hex_segs), 32'(SEGS_OFF));
    check("rst_out", 32'(out_port), 32'd0);
    check("rst_ph", 32'(blink_phase), 32'd1);
    rd("rst_period", 3'd3, 32'd25000000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("first_edge_segs", 32'(hex_segs), 32'(SEGS_ZERO));

    // DATA write, upper writedata bits ignored, one-cycle segment latency
    wr(3'd0, 32'hFFFF12AF);
    check("data_out", 32'(out_port), 32'h12AF);
    check("segs_latency", 32'(hex_segs), 32'(SEGS_ZERO));
    tick();
    check("data_segs", 32'(hex_segs), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));
    rd("rd_data", 3'd0, 32'h0000_12AF);

    // OUTSET / OUTCLEAR and write qualification
    wr(3'd0, 32'h00F0);
    wr(3'd4, 32'h0003);
    check("outset", 32'(out_port), 32'h00F3);
    wr(3'd5, 32'h0030);
    check("outclear", 32'(out_port), 32'h00C3);
    rd("rd_outset", 3'd4, 32'd0);
    rd("rd_outclear", 3'd5, 32'd0);
    rd("rd_rsvd", 3'd7, 32'd0);
    bus(3'd0, 32'h5555, 1'b0, 1'b0);
    check("no_cs", 32'(out_port), 32'h00C3);
    bus(3'd0, 32'h5555, 1'b1, 1'b1);
    check("no_wn", 32'(out_port), 32'h00C3);

    // Blink digit0 with PERIOD=3: digits 3..0 = 0,0,C,3
    wr(3'd2, 32'hFFFF_FFF1);
    rd("rd_blink", 3'd2, 32'h1);
    wr(3'd3, 32'd3);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      exp_ph = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      check($sformatf("blink3_ph_%0d", k), 32'(blink_phase), 32'(exp_ph));
      exp_segs = (k <= 3) ? {7'h40, 7'h40, 7'h46, 7'h30} : {7'h40, 7'h40, 7'h46, 7'h7F};
      check($sformatf("blink3_segs_%0d", k), 32'(hex_segs), 32'(exp_segs));
    end

    // BLANK takes precedence over BLINK on digit1, PERIOD=2
    wr(3'd2, 32'h2);
    wr(3'd1, 32'h2);
    rd("rd_blank", 3'd1, 32'h2);
    wr(3'd3, 32'd2);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      exp_ph = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      check($sformatf("blank_ph_%0d", k), 32'(blink_phase), 32'(exp_ph));
      check($sformatf("blank_d1_%0d", k), 32'(hex_segs[13:7]), 32'h7F);
      check($sformatf("blank_d0_%0d", k), 32'(hex_segs[6:0]), 32'h30);
    end
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h0);

    // PERIOD write coinciding with a wrap restarts visible with cnt=0
    wr(3'd3, 32'd4);
    tick();
    tick();
    tick();
    wr(3'd3, 32'd5);
    check("wrap_prio_ph", 32'(blink_phase), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_ph = (k == 5) ? 1'b0 : 1'b1;
      check($sformatf("reload_ph_%0d", k), 32'(blink_phase), 32'(exp_ph));
    end
    rd("rd_period5", 3'd3, 32'd5);

    // PERIOD=0 holds phase visible
    wr(3'd3, 32'd0);
    check("period0_ph", 32'(blink_phase), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("period0_hold_%0d", k), 32'(blink_phase), 32'd1);
    end
    rd("rd_period0", 3'd3, 32'd0);

    // Asynchronous reset mid-blink while ph=0
    wr(3'd0, 32'hABCD);
    wr(3'd2, 32'h1);
    wr(3'd3, 32'd3);
    tick();
    tick();
    tick();
    check("pre_reset_ph", 32'(blink_phase), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_ph", 32'(blink_phase), 32'd1);
    check("async_segs", 32'(hex_segs), 32'(SEGS_OFF));
    check("async_out", 32'(out_port), 32'd0);
    rd("async_rd_data", 3'd0, 32'd0);
    rd("async_rd_blink", 3'd2, 32'd0);
    rd("async_rd_period", 3'd3, 32'd25000000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rerelease_segs", 32'(hex_segs), 32'(SEGS_ZERO));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/finalproject1_soc_hex_display_pio.md
FINALPROJECT1_SOC_HEX_DISPLAY_PIO -- requirements
Module: finalproject1_soc_hex_display_pio

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, legal range 1..8: number of hex digits driven.
REQ-002 SHALL have parameter BLINK_RESET_PERIOD, default 25000000: reset value of the blink half-period register, in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port address, input, 3 bits: Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port readdata, output, 32 bits: read data, zero wait states, read latency 0.
REQ-010 SHALL have port out_port, output, 4*NUM_DIGITS bits: raw digit data register.
REQ-011 SHALL have port hex_segs, output, 7*NUM_DIGITS bits: active-low segments; digit i occupies [7i+6:7i], with bit 0 = a through bit 6 = g.
REQ-012 SHALL have port blink_phase, output, 1 bit: current blink phase; 1 = visible.

Function
REQ-013 A write SHALL occur when chipselect=1 and write_n=0; all other cycles SHALL leave the registers unchanged.
REQ-014 Register map (W = 4*NUM_DIGITS):
- 0 DATA, RW, W bits.
- 1 BLANK mask, RW, NUM_DIGITS bits.
- 2 BLINK mask, RW, NUM_DIGITS bits.
- 3 PERIOD, RW, 32 bits.
- 4 OUTSET, WO: DATA <= DATA | writedata[W-1:0].
- 5 OUTCLEAR, WO: DATA <= DATA & ~writedata[W-1:0].
- 6-7 reserved.
REQ-015 Writes SHALL use the low register-width bits of writedata; the upper bits SHALL be ignored.
REQ-016 readdata SHALL be combinational from address, zero-extended to 32 bits; addresses 4-7 SHALL read 0, and no read SHALL have side effects.
REQ-017 SHALL contain a 32-bit blink counter cnt and a phase register ph; blink_phase SHALL equal ph.
REQ-018 When PERIOD != 0 and no PERIOD write occurs: if cnt == PERIOD-1, then cnt <= 0 and ph <= ~ph; otherwise cnt <= cnt+1.
REQ-019 When PERIOD == 0: cnt SHALL hold at 0 and ph SHALL hold at 1 (blinking disabled).
REQ-020 A write to PERIOD SHALL load the new value and, in the same edge, set cnt <= 0 and ph <= 1; this SHALL take priority over a simultaneous wrap.
REQ-021 Digit i decode SHALL be the standard active-low hex font for 0-F: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, 7-bit).
REQ-022 Digit i SHALL be forced to 7F (off) when BLANK[i]=1, or when BLINK[i]=1 and ph=0; BLANK SHALL take precedence.
REQ-023 hex_segs SHALL be registered: it reflects the DATA/BLANK/BLINK/ph values present before edge N at edge N+1, i.e. one cycle after a register write lands.
REQ-024 out_port SHALL equal DATA combinationally, with no added latency.

Reset
REQ-025 While reset_n=0, and immediately on its assertion, even mid-count or mid-write, the block SHALL take these values:
- DATA=0, BLANK=0, BLINK=0, PERIOD=BLINK_RESET_PERIOD.
- cnt=0, ph=1.
- hex_segs all ones (all digits off), out_port=0.
REQ-026 On the first clk edge after reset release, hex_segs SHALL show 40 on every digit.

Verification
REQ-027 Reset, then write DATA=0x12AF with NUM_DIGITS=4 -> out_port=0x12AF on the next cycle; hex_segs = {79,24,08,0E} (digit3..0) one cycle later; read addr0 = 0x000012AF.
REQ-028 DATA=0x00F0, then OUTSET 0x0003, then OUTCLEAR 0x0030 -> DATA = 0x00F3, then 0x00C3; reads of addr4 and addr5 return 0.
REQ-029 PERIOD=3, BLINK=0x1 -> ph toggles every 3 cycles (3 visible, 3 off); digit0 alternates between its glyph and 7F, while digits 1-3 stay steady.
REQ-030 BLANK=0x2 with BLINK=0x2, PERIOD=2 -> digit1 stays 7F through both phases.
REQ-031 PERIOD=4, then write PERIOD=5 on the same edge that cnt wraps -> ph stays 1 and cnt=0; the next toggle occurs 5 cycles later. Writing PERIOD=0 -> ph is held at 1 indefinitely.
REQ-032 Assert reset_n=0 asynchronously mid-blink with ph=0 -> ph=1, hex_segs all ones, and all registers at their reset values before the next clk edge.
